pipe_ctrl: RTL and testbench

//  Pipeline control for the 5-stage MIPS core; producer of stall[5:0] consumed by pc_reg, if_id, id_ex, ex_mem, mem_wb.

---
 rtl/cpu_defs.sv | 39 +++
 rtl/sat_counter.sv | 27 ++
 rtl/pipe_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared pipeline-control definitions for the 5-stage core:
// stall encodings, stage bit indices and control FSM state codes.
package cpu_defs;

    // Stall vectors, one per deepest requester. A set bit freezes that
    // stage; bit 5 (WB) is never frozen so the pipe always drains.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    // Stage bit indices into the stall vector.
    localparam int STG_PC = 0;
    localparam int STG_WB = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_t;

    // Deepest requester wins; a deeper stall already covers the shallower ones.
    function automatic logic [5:0] stall_merge(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [5:0] v;
        v = STALL_NONE;
        if (req_mem)     v = STALL_MEM;
        else if (req_ex) v = STALL_EX;
        else if (req_id) v = STALL_ID;
        else if (req_if) v = STALL_IF;
        return v;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), i_inc, i_clr, o_q[W-1:0].
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests, sequences exception
// flush/redirect (deferred behind memory), stall statistics and watchdog.
// Ports: clk, rst (sync, active-high); stallreq_if/id/ex/mem;
//        excp_valid, excp_vector[31:0]; stall[5:0], flush, new_pc[31:0],
//        stall_cycles[CNT_W-1:0], stall_timeout (sticky).
module pipe_ctrl
    import cpu_defs::*;
#(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic [31:0]      excp_vector,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);

    // Run counter only needs to reach MAX_STALL; it saturates beyond.
    localparam int RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STALL - 1);

    ctrl_state_t r_state;
    logic [31:0] r_vec;
    logic        r_flush;
    logic [31:0] r_new_pc;
    logic        r_timeout;

    logic [5:0]       w_req_stall;
    logic [5:0]       w_stall;
    logic             w_stall_pc;
    logic [RUN_W-1:0] w_run_q;

    assign w_req_stall = stall_merge(stallreq_if, stallreq_id,
                                     stallreq_ex, stallreq_mem);

    // The flush cycle overrides requests so the cleared registers load
    // bubbles; during reset nothing is held.
    assign w_stall = (rst || (r_state == ST_FLUSH)) ? STALL_NONE
                                                    : w_req_stall;
    assign w_stall_pc = w_stall[STG_PC];

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_stall_pc),
        .i_clr (1'b0),
        .o_q   (stall_cycles)
    );

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_stall_pc),
        .i_clr (!w_stall_pc),
        .o_q   (w_run_q)
    );

    // FSM plus registered flush/new_pc. flush is high exactly while in
    // FLUSH, since it is set on the edge that enters that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_vec    <= 32'h0;
            r_flush  <= 1'b0;
            r_new_pc <= 32'h0;
        end else begin
            r_flush <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (excp_valid) begin
                        r_vec <= excp_vector;
                        if (!stallreq_mem) begin
                            r_state  <= ST_FLUSH;
                            r_flush  <= 1'b1;
                            r_new_pc <= excp_vector;
                        end else begin
                            r_state <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    // First exception wins; later ones are dropped.
                    if (!stallreq_mem) begin
                        r_state  <= ST_FLUSH;
                        r_flush  <= 1'b1;
                        r_new_pc <= r_vec;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky watchdog: set on the edge the run counter becomes MAX_STALL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_stall_pc && (w_run_q == RUN_LAST)) begin
            r_timeout <= 1'b1;
        end
    end

    assign stall         = w_stall;
    assign flush         = r_flush;
    assign new_pc        = r_new_pc;
    assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (CNT_W=4, MAX_STALL=8).
// Driver pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_pipe_ctrl;

    localparam int CNT_W     = 4;
    localparam int MAX_STALL = 8;

    typedef struct {
        logic [5:0]       stall;
        logic             flush;
        logic [31:0]      new_pc;
        logic [CNT_W-1:0] cyc;
        logic             tmo;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             excp_valid;
    logic [31:0]      excp_vector;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] stall_cycles;
    logic             stall_timeout;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    // Bench model of the registered outputs as seen in the current cycle.
    int          m_cyc;
    int          m_run;
    logic        m_to;
    logic [31:0] m_pc;

    pipe_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .excp_valid    (excp_valid),
        .excp_vector   (excp_vector),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_cycles  (stall_cycles),
        .stall_timeout (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: req = {mem, ex, id, if}. es/ef/epc are hand-computed
    // expectations for this cycle; epc is only used when ef=1.
    task automatic step(
        input logic        r,
        input logic [3:0]  req,
        input logic        ev,
        input logic [31:0] vec,
        input logic [5:0]  es,
        input logic        ef,
        input logic [31:0] epc
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        stallreq_mem = req[3];
        stallreq_ex  = req[2];
        stallreq_id  = req[1];
        stallreq_if  = req[0];
        excp_valid   = ev;
        excp_vector  = vec;
        if (ef) m_pc = epc;
        e.stall  = es;
        e.flush  = ef;
        e.new_pc = m_pc;
        e.cyc    = CNT_W'(m_cyc);
        e.tmo    = m_to;
        sb.push_back(e);
        if (r) begin
            m_cyc = 0;
            m_run = 0;
            m_to  = 1'b0;
            m_pc  = 32'h0;
        end else if (es[0]) begin
            if (m_cyc < 15) m_cyc++;
            if (m_run == MAX_STALL - 1) m_to = 1'b1;
            if (m_run < 15) m_run++;
        end else begin
            m_run = 0;
        end
    endtask

    task automatic gap();
        step(1'b0, 4'h0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (stall !== e.stall) begin
                n_err++;
                $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, e.stall);
            end
            n_vec++;
            if (flush !== e.flush) begin
                n_err++;
                $display("FAIL flush t=%0t got=%b exp=%b", $time, flush, e.flush);
            end
            n_vec++;
            if (new_pc !== e.new_pc) begin
                n_err++;
                $display("FAIL new_pc t=%0t got=%h exp=%h", $time, new_pc, e.new_pc);
            end
            n_vec++;
            if (stall_cycles !== e.cyc) begin
                n_err++;
                $display("FAIL stall_cycles t=%0t got=%0d exp=%0d",
                         $time, stall_cycles, e.cyc);
            end
            n_vec++;
            if (stall_timeout !== e.tmo) begin
                n_err++;
                $display("FAIL stall_timeout t=%0t got=%b exp=%b",
                         $time, stall_timeout, e.tmo);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "tb_pipe_ctrl hung");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        m_cyc = 0;
        m_run = 0;
        m_to  = 1'b0;
        m_pc  = 32'h0;
        rst          = 1'b1;
        stallreq_if  = 1'b1;
        stallreq_id  = 1'b1;
        stallreq_ex  = 1'b1;
        stallreq_mem = 1'b1;
        excp_valid   = 1'b0;
        excp_vector  = 32'h0;
        @(posedge clk);

        // Reset held with every request high, then release.
        repeat (3) step(1'b1, 4'hF, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0);
        step(1'b0, 4'hF, 1'b0, 32'h0, 6'b011111, 1'b0, 32'h0);
        gap();

        // Single-request sweep plus id+ex.
        step(1'b0, 4'b0001, 1'b0, 32'h0, 6'b000011, 1'b0, 32'h0);
        gap();
        step(1'b0, 4'b0010, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0);
        gap();
        step(1'b0, 4'b0100, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0);
        gap();
        step(1'b0, 4'b1000, 1'b0, 32'h0, 6'b011111, 1'b0, 32'h0);
        gap();
        step(1'b0, 4'b0110, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0);
        gap();

        // Watchdog: 7 stalled, 1 free, 7 stalled -> never times out.
        repeat (7) step(1'b0, 4'b0100, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0);
        gap();
        repeat (7) step(1'b0, 4'b0100, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0);
        gap();
        gap();

        // Exception without mem stall; flush cycle ignores requests.
        step(1'b0, 4'h0, 1'b1, 32'h0000_0180, 6'b000000, 1'b0, 32'h0);
        step(1'b0, 4'hF, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h0000_0180);
        gap();

        // A different vector so the deferred case below is distinguishable.
        step(1'b0, 4'h0, 1'b1, 32'h0000_0040, 6'b000000, 1'b0, 32'h0);
        step(1'b0, 4'h0, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h0000_0040);
        gap();

        // Deferred behind mem for 4 cycles; second exception ignored.
        step(1'b0, 4'b1000, 1'b1, 32'h0000_0180, 6'b011111, 1'b0, 32'h0);
        step(1'b0, 4'b1000, 1'b1, 32'h0000_0200, 6'b011111, 1'b0, 32'h0);
        step(1'b0, 4'b1000, 1'b0, 32'h0, 6'b011111, 1'b0, 32'h0);
        step(1'b0, 4'b1100, 1'b0, 32'h0, 6'b011111, 1'b0, 32'h0);
        step(1'b0, 4'b0000, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0);
        step(1'b0, 4'b0000, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h0000_0180);
        gap();

        // Level exception: ignored during FLUSH, taken again in IDLE.
        step(1'b0, 4'h0, 1'b1, 32'h0000_0300, 6'b000000, 1'b0, 32'h0);
        step(1'b0, 4'h0, 1'b1, 32'h0000_0308, 6'b000000, 1'b1, 32'h0000_0300);
        step(1'b0, 4'h0, 1'b1, 32'h0000_0304, 6'b000000, 1'b0, 32'h0);
        step(1'b0, 4'h0, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h0000_0304);
        gap();

        // Reset during FLUSH abandons everything.
        step(1'b0, 4'h0, 1'b1, 32'h0000_0500, 6'b000000, 1'b0, 32'h0);
        step(1'b1, 4'h0, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h0000_0500);
        gap();

        // 20 continuous stall cycles: timeout after 8, count saturates at 15.
        repeat (20) step(1'b0, 4'b0100, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0);
        repeat (3) gap();

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
